// File: rtl/opl3_pkg.sv
// opl3_pkg: shared operator-slot constants and slot decoding helpers
package opl3_pkg;
  localparam int NUM_BANKS = 2;
  localparam int BANK_NUM_WIDTH = 1;
  localparam int OP_NUM_WIDTH = 5;
  localparam int CH_PER_BANK = 9;
  localparam int OP_OUT_WIDTH = 13;
  localparam logic [OP_NUM_WIDTH-1:0] LAST_OP = 5'd17;
  function automatic logic op_is_carrier(input logic [OP_NUM_WIDTH-1:0] op);
    return op % 5'd6 >= 5'd3;
  endfunction
  function automatic logic [3:0] op_to_channel(input logic [OP_NUM_WIDTH-1:0] op);
    return 4'(op / 5'd6 * 5'd3 + op % 5'd3);
  endfunction
endpackage

// File: rtl/operator_mixer_if.sv
// operator_mixer_if: operator output stream in, modulation for the next slot back out
interface operator_mixer_if #(
  parameter int OP_W = 13
);
  import opl3_pkg::*;
  logic op_valid;
  logic [BANK_NUM_WIDTH-1:0] bank_num;
  logic [OP_NUM_WIDTH-1:0] op_num;
  logic signed [OP_W-1:0] op_out;
  logic signed [OP_W-1:0] modulation;
  modport master (output op_valid, bank_num, op_num, op_out, input modulation);
  modport slave (input op_valid, bank_num, op_num, op_out, output modulation);
endinterface

// File: rtl/operator_feedback.sv
// operator_feedback: per-channel modulator history and self-feedback modulation
module operator_feedback import opl3_pkg::*; #(
  parameter int OP_W = 13,
  parameter int CH_PER_BANK = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic wr_bank,
  input  logic [3:0] wr_ch,
  input  logic signed [OP_W-1:0] wr_data,
  input  logic rd_bank,
  input  logic [3:0] rd_ch,
  input  logic [2:0] fb_lvl,
  output logic signed [OP_W-1:0] fb_mod
);
  logic signed [OP_W-1:0] h0_q [NUM_BANKS][CH_PER_BANK];
  logic signed [OP_W-1:0] h0_d [NUM_BANKS][CH_PER_BANK];
  logic signed [OP_W-1:0] h1_q [NUM_BANKS][CH_PER_BANK];
  logic signed [OP_W-1:0] h1_d [NUM_BANKS][CH_PER_BANK];
  logic signed [OP_W:0] sum;
  always_comb begin
    h0_d = h0_q;
    h1_d = h1_q;
    if (wr_en) begin
      h1_d[wr_bank][wr_ch] = h0_q[wr_bank][wr_ch];
      h0_d[wr_bank][wr_ch] = wr_data;
    end
    sum = (OP_W+1)'(h0_q[rd_bank][rd_ch]) + (OP_W+1)'(h1_q[rd_bank][rd_ch]);
    fb_mod = fb_lvl == 3'd0 ? '0 : OP_W'(sum >>> (4'd9 - 4'(fb_lvl)));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h0_q <= '{default: '0};
      h1_q <= '{default: '0};
    end else begin
      h0_q <= h0_d;
      h1_q <= h1_d;
    end
endmodule

// File: rtl/operator_mixer.sv
// operator_mixer: per-slot modulation routing, channel sums and saturated sample mix
module operator_mixer import opl3_pkg::*; #(
  parameter int OP_W = 13,
  parameter int CH_PER_BANK = 9,
  parameter int SAMPLE_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_clk_en,
  input  logic is_new,
  operator_mixer_if.slave op_if,
  input  logic [NUM_BANKS-1:0][CH_PER_BANK-1:0] cnt,
  input  logic [NUM_BANKS-1:0][CH_PER_BANK-1:0][2:0] fb,
  output logic channel_valid,
  output logic channel_bank,
  output logic [3:0] channel_num,
  output logic signed [OP_W:0] channel_out,
  output logic sample_valid,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic seq_err
);
  localparam int ACC_W = 20;
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;
  logic bank_q, bank_d, nb;
  logic [OP_NUM_WIDTH-1:0] op_q, op_d, no;
  logic signed [OP_W-1:0] mod_buf_q [3];
  logic signed [OP_W-1:0] mod_buf_d [3];
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic done_q, done_d, seq_err_q, seq_err_d;
  logic signed [OP_W-1:0] modulation_q, modulation_d, fb_mod;
  logic ch_valid_q, ch_valid_d, ch_bank_q, ch_bank_d;
  logic [3:0] ch_num_q, ch_num_d, ch, nch;
  logic signed [OP_W:0] ch_out_q, ch_out_d, ch_sum;
  logic smp_valid_q, smp_valid_d;
  logic signed [SAMPLE_W-1:0] smp_out_q, smp_out_d;
  logic hit, carrier, last, upd, ncar;
  logic [1:0] mi, nmi;
  always_comb begin
    hit = op_if.op_valid && !sample_clk_en && op_if.bank_num == bank_q && op_if.op_num == op_q;
    carrier = op_is_carrier(op_q);
    ch = op_to_channel(op_q);
    mi = 2'(op_q % 5'd3);
    last = op_q == LAST_OP && (bank_q || !is_new);
    nb = last ? 1'b0 : op_q == LAST_OP ? 1'b1 : bank_q;
    no = op_q == LAST_OP ? '0 : op_q + 5'd1;
    bank_d = sample_clk_en ? 1'b0 : hit ? nb : bank_q;
    op_d = sample_clk_en ? '0 : hit ? no : op_q;
    nch = op_to_channel(op_d);
    ncar = op_is_carrier(op_d);
    nmi = 2'(op_d % 5'd3);
    upd = hit || sample_clk_en;
  end
  // The next modulator slot never belongs to the channel being written, so history is read pre-update.
  operator_feedback #(.OP_W(OP_W), .CH_PER_BANK(CH_PER_BANK)) u_fb (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(hit && !carrier),
    .wr_bank(bank_q),
    .wr_ch(ch),
    .wr_data(op_if.op_out),
    .rd_bank(bank_d),
    .rd_ch(nch),
    .fb_lvl(fb[bank_d][nch]),
    .fb_mod(fb_mod)
  );
  always_comb begin
    mod_buf_d = mod_buf_q;
    if (hit && !carrier) mod_buf_d[mi] = op_if.op_out;
    ch_sum = cnt[bank_q][ch] ? (OP_W+1)'(mod_buf_q[mi]) + (OP_W+1)'(op_if.op_out) : (OP_W+1)'(op_if.op_out);
    acc_d = ((done_q || sample_clk_en) ? '0 : acc_q) + ((hit && carrier) ? ACC_W'(ch_sum) : '0);
    done_d = hit && carrier && last;
    seq_err_d = seq_err_q || (op_if.op_valid && !sample_clk_en && !hit);
    ch_valid_d = hit && carrier;
    ch_bank_d = ch_valid_d ? bank_q : ch_bank_q;
    ch_num_d = ch_valid_d ? ch : ch_num_q;
    ch_out_d = ch_valid_d ? ch_sum : ch_out_q;
    smp_valid_d = done_q;
    smp_out_d = !done_q ? smp_out_q : acc_q > S_MAX ? SAMPLE_W'(S_MAX) : acc_q < S_MIN ? SAMPLE_W'(S_MIN) : SAMPLE_W'(acc_q);
    modulation_d = !upd ? modulation_q : !ncar ? fb_mod : cnt[bank_d][nch] ? '0 : mod_buf_d[nmi];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bank_q <= 1'b0;
      op_q <= '0;
      mod_buf_q <= '{default: '0};
      acc_q <= '0;
      done_q <= 1'b0;
      seq_err_q <= 1'b0;
      modulation_q <= '0;
      ch_valid_q <= 1'b0;
      ch_bank_q <= 1'b0;
      ch_num_q <= '0;
      ch_out_q <= '0;
      smp_valid_q <= 1'b0;
      smp_out_q <= '0;
    end else begin
      bank_q <= bank_d;
      op_q <= op_d;
      mod_buf_q <= mod_buf_d;
      acc_q <= acc_d;
      done_q <= done_d;
      seq_err_q <= seq_err_d;
      modulation_q <= modulation_d;
      ch_valid_q <= ch_valid_d;
      ch_bank_q <= ch_bank_d;
      ch_num_q <= ch_num_d;
      ch_out_q <= ch_out_d;
      smp_valid_q <= smp_valid_d;
      smp_out_q <= smp_out_d;
    end
  assign op_if.modulation = modulation_q;
  assign channel_valid = ch_valid_q;
  assign channel_bank = ch_bank_q;
  assign channel_num = ch_num_q;
  assign channel_out = ch_out_q;
  assign sample_valid = smp_valid_q;
  assign sample_out = smp_out_q;
  assign seq_err = seq_err_q;
endmodule

// File: tb/tb_operator_mixer.sv
// tb_operator_mixer: randomized operator walks checked against a slot-level behavioural model
module tb_operator_mixer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sample_clk_en = 1'b0;
  logic is_new = 1'b0;
  logic [1:0][8:0] cnt = '0;
  logic [1:0][8:0][2:0] fb = '0;
  logic channel_valid, channel_bank, sample_valid, seq_err;
  logic [3:0] channel_num;
  logic signed [13:0] channel_out;
  logic signed [15:0] sample_out;
  operator_mixer_if #(.OP_W(13)) op_if();
  operator_mixer dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_clk_en(sample_clk_en),
    .is_new(is_new),
    .op_if(op_if),
    .cnt(cnt),
    .fb(fb),
    .channel_valid(channel_valid),
    .channel_bank(channel_bank),
    .channel_num(channel_num),
    .channel_out(channel_out),
    .sample_valid(sample_valid),
    .sample_out(sample_out),
    .seq_err(seq_err)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int h0 [2][9];
  int h1 [2][9];
  int pend [3];
  int acc = 0;
  int vals [36];
  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int clamp(input int x);
    return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
  endfunction
  function automatic int exp_mod(input int b, input int o);
    int c;
    c = (o / 6) * 3 + o % 3;
    if (o % 6 >= 3) return cnt[b][c] ? 0 : pend[c % 3];
    if (fb[b][c] == 3'd0) return 0;
    return (h0[b][c] + h1[b][c]) >>> (9 - int'(fb[b][c]));
  endfunction
  task automatic model_reset();
    h0 = '{default: '{default: 0}};
    h1 = '{default: '{default: 0}};
    pend = '{default: 0};
    acc = 0;
  endtask
  task automatic send_op(input int b, input int o, input int v);
    int c, chv, nb, no;
    bit last;
    @(posedge clk);
    #1;
    op_if.op_valid = 1'b1;
    op_if.bank_num = b[0];
    op_if.op_num = 5'(o);
    op_if.op_out = 13'(v);
    @(posedge clk);
    #1;
    op_if.op_valid = 1'b0;
    c = (o / 6) * 3 + o % 3;
    last = o == 17 && (b == 1 || !is_new);
    if (o % 6 >= 3) begin
      chv = cnt[b][c] ? pend[c % 3] + v : v;
      acc += chv;
      chk("ch_valid", channel_valid, 1);
      chk("ch_num", channel_num, c);
      chk("ch_bank", channel_bank, b);
      chk("ch_out", channel_out, chv);
    end else begin
      h1[b][c] = h0[b][c];
      h0[b][c] = v;
      pend[o % 3] = v;
      chk("ch_idle", channel_valid, 0);
    end
    nb = last ? 0 : o == 17 ? 1 : b;
    no = o == 17 ? 0 : o + 1;
    chk("modulation", op_if.modulation, exp_mod(nb, no));
    if (last) begin
      chk("smp_early", sample_valid, 0);
      @(posedge clk);
      #1;
      chk("smp_valid", sample_valid, 1);
      chk("smp_out", sample_out, clamp(acc));
      acc = 0;
    end
  endtask
  task automatic walk(input int n);
    for (int i = 0; i < n; i++) send_op(i / 18, i % 18, vals[i]);
  endtask
  task automatic sclk();
    @(posedge clk);
    #1 sample_clk_en = 1'b1;
    @(posedge clk);
    #1 sample_clk_en = 1'b0;
    acc = 0;
    chk("sclk_mod", op_if.modulation, exp_mod(0, 0));
  endtask
  task automatic fill_rand();
    for (int i = 0; i < 36; i++) vals[i] = int'($urandom_range(8191)) - 4096;
  endtask
  task automatic fill_const(input int v);
    for (int i = 0; i < 36; i++) vals[i] = v;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_chv"}, channel_valid, 0);
    chk({tag, "_chb"}, channel_bank, 0);
    chk({tag, "_chn"}, channel_num, 0);
    chk({tag, "_cho"}, channel_out, 0);
    chk({tag, "_smv"}, sample_valid, 0);
    chk({tag, "_smo"}, sample_out, 0);
    chk({tag, "_mod"}, op_if.modulation, 0);
    chk({tag, "_err"}, seq_err, 0);
  endtask
  initial begin
    op_if.op_valid = 1'b0;
    op_if.bank_num = '0;
    op_if.op_num = '0;
    op_if.op_out = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fill_const(0);
    vals[0] = 100;
    vals[3] = -50;
    sclk();
    walk(18);
    cnt[0][0] = 1'b1;
    sclk();
    walk(18);
    @(posedge clk);
    #1;
    sample_clk_en = 1'b1;
    op_if.op_valid = 1'b1;
    op_if.bank_num = 1'b0;
    op_if.op_num = 5'd0;
    op_if.op_out = 13'sd1234;
    @(posedge clk);
    #1;
    sample_clk_en = 1'b0;
    op_if.op_valid = 1'b0;
    acc = 0;
    chk("sclk_op_err", seq_err, 0);
    chk("sclk_op_mod", op_if.modulation, exp_mod(0, 0));
    cnt = '0;
    fb[0][0] = 3'd1;
    fill_const(0);
    vals[0] = 256;
    sclk();
    walk(18);
    sclk();
    walk(18);
    sclk();
    chk("fb1", op_if.modulation, 2);
    fb[0][0] = 3'd7;
    sclk();
    chk("fb7", op_if.modulation, 128);
    fb[0][0] = 3'd0;
    sclk();
    chk("fb0", op_if.modulation, 0);
    is_new = 1'b1;
    cnt = '1;
    fill_const(4095);
    sclk();
    walk(36);
    chk("sat_hi", sample_out, 32767);
    fill_const(-4096);
    sclk();
    walk(36);
    chk("sat_lo", sample_out, -32768);
    repeat (12) begin
      is_new = 1'($urandom_range(1));
      cnt = 18'($urandom);
      fb = 54'({$urandom, $urandom});
      fill_rand();
      sclk();
      walk(is_new ? 36 : 18);
    end
    is_new = 1'b1;
    fill_rand();
    sclk();
    walk(9);
    sclk();
    repeat (3) begin
      @(posedge clk);
      #1 chk("partial_none", sample_valid, 0);
    end
    fill_rand();
    walk(36);
    is_new = 1'b0;
    fill_rand();
    sclk();
    walk(18);
    @(posedge clk);
    #1;
    op_if.op_valid = 1'b1;
    op_if.bank_num = 1'b1;
    op_if.op_num = 5'd0;
    op_if.op_out = 13'sd77;
    @(posedge clk);
    #1 op_if.op_valid = 1'b0;
    chk("seq_err", seq_err, 1);
    chk("seq_no_ch", channel_valid, 0);
    chk("seq_mod", op_if.modulation, exp_mod(0, 0));
    is_new = 1'b1;
    cnt = '1;
    fb = 54'({$urandom, $urandom}) | {18{3'b001}};
    fill_const(1000);
    sclk();
    walk(10);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    fill_rand();
    sclk();
    walk(36);
    sclk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/operator_mixer.md
# operator_mixer

Time-multiplexed consumer of the phase generator's per-operator output stream and producer of its `modulation` input. It sits directly after the phase generator in the operator pipeline. Per slot it does three things: keeps modulator feedback history, forwards modulator outputs to their carriers (FM) or adds them (AM), and emits per-channel sums. It also emits one saturated 16-bit mixed sample per sample period. Only 2-operator channels are handled; 4-op pairing and rhythm remapping are out of scope, and rhythm channels are mixed as normal channels.

## Interface
Parameters:
- `OP_W`, 13: signed operator output width (equals `OP_OUT_WIDTH`).
- `CH_PER_BANK`, 9: channels per bank.
- `SAMPLE_W`, 16: mixed sample width.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_clk_en`  in  1  start-of-sample pulse.
- `is_new`  in  1  OPL3 mode; when 0, bank 1 is not walked.
- `op_valid`  in  1  single-cycle pulse: `op_out` is valid for the slot `bank_num`/`op_num`.
- `bank_num`  in  `BANK_NUM_WIDTH`  bank of the arriving operator.
- `op_num`  in  `OP_NUM_WIDTH`  operator index, 0–17.
- `op_out`  in  `OP_W`  signed operator output.
- `cnt`  in  [NUM_BANKS][CH_PER_BANK]  connection bit: 0 = FM, 1 = AM.
- `fb`  in  [NUM_BANKS][CH_PER_BANK][3]  feedback level per channel.
- `modulation`  out  `OP_W`  modulation for the next expected slot.
- `channel_valid`  out  1  channel result strobe.
- `channel_bank`  out  1  bank of the channel result.
- `channel_num`  out  4  channel index of the result, 0–8.
- `channel_out`  out  `OP_W+1`  signed channel sum.
- `sample_valid`  out  1  mixed-sample strobe.
- `sample_out`  out  `SAMPLE_W`  signed saturated mix.
- `seq_err`  out  1  sticky sequence-error flag.

## Operation
Slot mapping:
- Channel c uses modulator op `m = (c/3)*6 + c%3` and carrier op `m+3`.
- Arrival order is strictly op 0..17 of bank 0, then, if `is_new`, op 0..17 of bank 1.

Per-slot processing:
- An expected-slot counter (bank, op) resets to (0,0) on `sample_clk_en`.
- An `op_valid` whose bank/op differs from the expected slot is discarded and sets `seq_err`. `seq_err` clears only on reset.
- Modulator arrival: history shift `h1<=h0`, `h0<=op_out` for that channel. The value is also stored in a 3-entry pending-modulator buffer indexed by `c%3`.
- Carrier arrival:
  - `channel_out = cnt ? sign_ext(mod_buf) + op_out : sign_ext(op_out)`.
  - The result is added into a 20-bit signed sample accumulator.

`modulation` is always computed for the next expected slot:
- Next slot is a modulator: if `fb==0`, 0. Otherwise `(h0+h1) >>> (9-fb)`, where `h0+h1` is a 14-bit signed sum, then truncated to `OP_W`.
- Next slot is a carrier: if `cnt==0`, `mod_buf[c%3]`; otherwise 0.
- The next slot after the final op of a sample is bank 0 op 0.

Sample completion:
- The sample completes on the last carrier: bank 0 op 17 if `!is_new`, else bank 1 op 17.
- `sample_out` is the accumulator saturated to [-32768, 32767]. The accumulator then clears.
- `sample_clk_en` arriving mid-walk drops the partial sample: accumulator clears, no `sample_valid`. History is kept.
- `sample_clk_en` and `op_valid` in the same cycle: `sample_clk_en` wins and the op is discarded. This is not an error.

## Timing
- Reset: all outputs 0; history, buffer and accumulator 0; expected slot (0,0).
- `modulation` is registered and updates 1 cycle after each accepted `op_valid`, and 1 cycle after `sample_clk_en`.
- `channel_valid`/`channel_bank`/`channel_num`/`channel_out` assert 1 cycle after a carrier `op_valid`, for 1 cycle. `channel_out` holds its value afterward.
- `sample_valid` asserts 2 cycles after the final carrier `op_valid` (accumulate, then saturate), for 1 cycle. `sample_out` holds its value.
- `op_valid` pulses must be at least 2 cycles apart.

## Structure
- `opl3_pkg`: `CH_PER_BANK` constant; functions `op_is_carrier(op)` and `op_to_channel(op)`.
- Sub-module `operator_feedback`: history RAM read, then `(h0+h1) >>> (9-fb)`.
- Everything else lives in the top module.

## Test plan
- FM, channel 0 bank 0, `cnt=0`: op0 `op_out=100`; after op2, `modulation=100`. Op3 `op_out=-50` gives `channel_out=-50`.
- AM, `cnt=1`: mod 100, carrier -50 gives `channel_out=50` 1 cycle after the carrier; `modulation` is 0 before op3.
- Feedback: `fb=1`, two modulator outputs of 256 gives `modulation=2` for that slot next sample. `fb=7` gives 128; `fb=0` gives 0.
- Saturation, `is_new=1`, all `cnt=1`:
  - All ops 4095: `sample_out=32767`.
  - All ops -4096: `sample_out=-32768`.
  - `sample_valid` asserts 2 cycles after bank 1 op 17.
- `is_new=0`: the sample completes after bank 0 op 17. A following bank 1 op sets `seq_err`.
- `sample_clk_en` asserted after op 8: no `sample_valid`. The next full walk sums only its own ops. Assert `rst_n` low mid-walk: all outputs 0 immediately.
